// File: rtl/cp0_reg_pkg.sv
// rtl/cp0_reg_pkg.sv - CP0 register numbers, field positions and exception codes shared with the encoder
package cp0_reg_pkg;

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;

  localparam int STATUS_IE     = 0;
  localparam int STATUS_EXL    = 1;
  localparam int STATUS_IM_LO  = 8;
  localparam int STATUS_IM_HI  = 15;

  localparam int CAUSE_EXC_LO  = 2;
  localparam int CAUSE_EXC_HI  = 6;
  localparam int CAUSE_IP_LO   = 8;
  localparam int CAUSE_SWIP_HI = 9;
  localparam int CAUSE_HWIP_LO = 10;
  localparam int CAUSE_IP_HI   = 15;
  localparam int CAUSE_BD      = 31;

  localparam logic [31:0] EXC_NONE    = 32'd0;
  localparam logic [31:0] EXC_INT0    = 32'd1;
  localparam logic [31:0] EXC_INT7    = 32'd8;
  localparam logic [31:0] EXC_SYSCALL = 32'd9;
  localparam logic [31:0] EXC_RI      = 32'd10;
  localparam logic [31:0] EXC_OV      = 32'd11;
  localparam logic [31:0] EXC_ADEL    = 32'd12;
  localparam logic [31:0] EXC_ERET    = 32'd13;

  localparam logic [4:0] EXCCODE_INT  = 5'd0;
  localparam logic [4:0] EXCCODE_ADEL = 5'd4;
  localparam logic [4:0] EXCCODE_SYS  = 5'd8;
  localparam logic [4:0] EXCCODE_RI   = 5'd10;
  localparam logic [4:0] EXCCODE_OV   = 5'd12;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_EXC,
    EV_ERET
  } exc_event_e;

  // Codes outside 1..13 (including any upper-bit garbage) are treated as no event.
  function automatic exc_event_e classify_exc(input logic [31:0] code);
    if (code >= EXC_INT0 && code <= EXC_ADEL) begin
      return EV_EXC;
    end else if (code == EXC_ERET) begin
      return EV_ERET;
    end
    return EV_NONE;
  endfunction

  function automatic logic [4:0] exccode_of(input logic [31:0] code);
    case (code)
      EXC_SYSCALL: return EXCCODE_SYS;
      EXC_RI:      return EXCCODE_RI;
      EXC_OV:      return EXCCODE_OV;
      EXC_ADEL:    return EXCCODE_ADEL;
      default:     return EXCCODE_INT;
    endcase
  endfunction

endpackage

// File: rtl/cp0_reg_if.sv
// rtl/cp0_reg_if.sv - pipeline-facing CP0 access, exception and redirect signals
interface cp0_reg_if;

  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [4:0]  raddr_i;
  logic [31:0] rdata_o;
  logic [5:0]  int_i;
  logic [31:0] excepttype_i;
  logic [31:0] pc_i;
  logic        in_delayslot_i;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic [31:0] count_o;
  logic [31:0] compare_o;
  logic        timer_int_o;
  logic        flush_o;
  logic [31:0] new_pc_o;

  modport slave (
    input  we_i, waddr_i, wdata_i, raddr_i, int_i, excepttype_i, pc_i, in_delayslot_i,
    output rdata_o, status_o, cause_o, epc_o, count_o, compare_o, timer_int_o, flush_o, new_pc_o
  );

  modport master (
    output we_i, waddr_i, wdata_i, raddr_i, int_i, excepttype_i, pc_i, in_delayslot_i,
    input  rdata_o, status_o, cause_o, epc_o, count_o, compare_o, timer_int_o, flush_o, new_pc_o
  );

endinterface

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - free-running Count, Compare and the sticky timer interrupt
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_int
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= 32'd0;
      compare   <= 32'd0;
      timer_int <= 1'b0;
    end else begin
      count <= count_we ? wdata : count + 32'd1;
      if (compare_we) begin
        compare <= wdata;
      end
      // A Compare write acknowledges the interrupt even if a match lands on the same edge.
      if (compare_we) begin
        timer_int <= 1'b0;
      end else if (count == compare && compare != 32'd0) begin
        timer_int <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_reg.sv
// rtl/cp0_reg.sv - CP0 register file: Status/Cause/EPC, exception entry, ERET and redirect
module cp0_reg
  import cp0_reg_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter logic [31:0] STATUS_RST = 32'h1000_0000
) (
  input logic       clk,
  input logic       rst,
  cp0_reg_if.slave  bus
);

  exc_event_e  ev;
  logic        flush;
  logic        wr_en;
  logic        bypass;
  logic        wr_count;
  logic        wr_compare;
  logic        wr_status;
  logic        wr_cause;
  logic        wr_epc;
  logic [31:0] status;
  logic [31:0] cause;
  logic [31:0] epc;
  logic [31:0] status_next;
  logic [31:0] cause_next;
  logic [31:0] epc_next;
  logic [31:0] cause_wmerge;
  logic [31:0] count;
  logic [31:0] compare;
  logic        timer_int;
  logic [31:0] rdata;
  logic [31:0] new_pc;

  assign ev    = classify_exc(bus.excepttype_i);
  assign flush = (ev != EV_NONE);

  // A flushing instruction must not retire its MTC0.
  assign wr_en      = bus.we_i && !flush;
  assign wr_count   = wr_en && (bus.waddr_i == REG_COUNT);
  assign wr_compare = wr_en && (bus.waddr_i == REG_COMPARE);
  assign wr_status  = wr_en && (bus.waddr_i == REG_STATUS);
  assign wr_cause   = wr_en && (bus.waddr_i == REG_CAUSE);
  assign wr_epc     = wr_en && (bus.waddr_i == REG_EPC);
  assign bypass     = wr_en && (bus.waddr_i == bus.raddr_i);

  always_comb begin
    cause_wmerge = cause;
    cause_wmerge[CAUSE_SWIP_HI:CAUSE_IP_LO] = bus.wdata_i[CAUSE_SWIP_HI:CAUSE_IP_LO];
  end

  cp0_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (wr_count),
    .compare_we (wr_compare),
    .wdata      (bus.wdata_i),
    .count      (count),
    .compare    (compare),
    .timer_int  (timer_int)
  );

  always_comb begin
    status_next = status;
    cause_next  = cause;
    epc_next    = epc;
    if (wr_status) begin
      status_next = bus.wdata_i;
    end
    if (wr_cause) begin
      cause_next = cause_wmerge;
    end
    if (wr_epc) begin
      epc_next = bus.wdata_i;
    end
    cause_next[CAUSE_IP_HI:CAUSE_HWIP_LO] = {bus.int_i[5] | timer_int, bus.int_i[4:0]};
    if (ev == EV_EXC) begin
      status_next[STATUS_EXL] = 1'b1;
      cause_next[CAUSE_EXC_HI:CAUSE_EXC_LO] = exccode_of(bus.excepttype_i);
      // Nested exceptions keep the original return point.
      if (!status[STATUS_EXL]) begin
        epc_next = bus.in_delayslot_i ? bus.pc_i - 32'd4 : bus.pc_i;
        cause_next[CAUSE_BD] = bus.in_delayslot_i;
      end
    end else if (ev == EV_ERET) begin
      status_next[STATUS_EXL] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status <= STATUS_RST;
      cause  <= 32'd0;
      epc    <= 32'd0;
    end else begin
      status <= status_next;
      cause  <= cause_next;
      epc    <= epc_next;
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (bus.raddr_i)
      REG_COUNT:   rdata = bypass ? bus.wdata_i : count;
      REG_COMPARE: rdata = bypass ? bus.wdata_i : compare;
      REG_STATUS:  rdata = bypass ? bus.wdata_i : status;
      REG_CAUSE:   rdata = bypass ? cause_wmerge : cause;
      REG_EPC:     rdata = bypass ? bus.wdata_i : epc;
      default:     rdata = 32'd0;
    endcase
  end

  always_comb begin
    new_pc = 32'd0;
    case (ev)
      EV_EXC:  new_pc = EXC_VECTOR;
      EV_ERET: new_pc = epc;
      default: new_pc = 32'd0;
    endcase
  end

  assign bus.rdata_o     = rdata;
  assign bus.status_o    = status;
  assign bus.cause_o     = cause;
  assign bus.epc_o       = epc;
  assign bus.count_o     = count;
  assign bus.compare_o   = compare;
  assign bus.timer_int_o = timer_int;
  assign bus.flush_o     = flush;
  assign bus.new_pc_o    = new_pc;

endmodule

// File: tb/tb_cp0_reg.sv
// tb/tb_cp0_reg.sv - scoreboard bench for cp0_reg: per-cycle reference model plus directed checks
module tb_cp0_reg;

  localparam logic [31:0] VEC  = 32'hBFC0_0380;
  localparam logic [31:0] SRST = 32'h1000_0000;

  localparam int S_STATUS  = 0;
  localparam int S_CAUSE   = 1;
  localparam int S_EPC     = 2;
  localparam int S_COUNT   = 3;
  localparam int S_COMPARE = 4;
  localparam int S_TIMER   = 5;
  localparam int S_FLUSH   = 6;
  localparam int S_NEWPC   = 7;
  localparam int S_RDATA   = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cp0_reg_if bus ();

  cp0_reg #(.EXC_VECTOR(VEC), .STATUS_RST(SRST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  string       tag_q[$];
  int          sig_q[$];
  logic [31:0] val_q[$];

  logic [31:0] m_status, m_cause, m_epc, m_count, m_compare;
  logic        m_timer;
  logic [31:0] n_status, n_cause, n_epc, n_count, n_compare;
  logic        n_timer;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [31:0] actual(input int sig);
    case (sig)
      S_STATUS:  return bus.status_o;
      S_CAUSE:   return bus.cause_o;
      S_EPC:     return bus.epc_o;
      S_COUNT:   return bus.count_o;
      S_COMPARE: return bus.compare_o;
      S_TIMER:   return {31'd0, bus.timer_int_o};
      S_FLUSH:   return {31'd0, bus.flush_o};
      S_NEWPC:   return bus.new_pc_o;
      default:   return bus.rdata_o;
    endcase
  endfunction

  task automatic push(input string tag, input int sig, input logic [31:0] val);
    tag_q.push_back(tag);
    sig_q.push_back(sig);
    val_q.push_back(val);
  endtask

  task automatic drain();
    while (tag_q.size() > 0) begin
      check(tag_q.pop_front(), actual(sig_q.pop_front()), val_q.pop_front());
    end
  endtask

  task automatic want(input string tag, input int sig, input logic [31:0] val);
    push(tag, sig, val);
    drain();
  endtask

  function automatic logic [4:0] ref_exccode(input logic [31:0] exc);
    case (exc)
      32'd9:   return 5'd8;
      32'd10:  return 5'd10;
      32'd11:  return 5'd12;
      32'd12:  return 5'd4;
      default: return 5'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_status = SRST; m_cause = '0; m_epc = '0;
    m_count = '0; m_compare = '0; m_timer = 1'b0;
  endtask

  // Drive one cycle of inputs, check combinational outputs, and stage the expected next state.
  task automatic drive(input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                       input logic [4:0] raddr, input logic [5:0] intr, input logic [31:0] exc,
                       input logic [31:0] pc, input logic ds);
    logic is_exc, is_eret, wr;
    logic [31:0] rd;
    bus.we_i = we; bus.waddr_i = waddr; bus.wdata_i = wdata; bus.raddr_i = raddr;
    bus.int_i = intr; bus.excepttype_i = exc; bus.pc_i = pc; bus.in_delayslot_i = ds;
    is_exc  = (exc >= 32'd1) && (exc <= 32'd12);
    is_eret = (exc == 32'd13);
    wr      = we && !(is_exc || is_eret);
    push("flush", S_FLUSH, {31'd0, is_exc || is_eret});
    push("new_pc", S_NEWPC, is_exc ? VEC : (is_eret ? m_epc : 32'd0));
    case (raddr)
      5'd9:    rd = m_count;
      5'd11:   rd = m_compare;
      5'd12:   rd = m_status;
      5'd13:   rd = m_cause;
      5'd14:   rd = m_epc;
      default: rd = 32'd0;
    endcase
    if (wr && waddr == raddr) begin
      if (raddr == 5'd9 || raddr == 5'd11 || raddr == 5'd12 || raddr == 5'd14) rd = wdata;
      if (raddr == 5'd13) rd = {m_cause[31:10], wdata[9:8], m_cause[7:0]};
    end
    push("rdata", S_RDATA, rd);

    n_count   = (wr && waddr == 5'd9) ? wdata : m_count + 32'd1;
    n_compare = (wr && waddr == 5'd11) ? wdata : m_compare;
    if (wr && waddr == 5'd11) n_timer = 1'b0;
    else if (m_count == m_compare && m_compare != 32'd0) n_timer = 1'b1;
    else n_timer = m_timer;
    n_status = (wr && waddr == 5'd12) ? wdata : m_status;
    n_epc    = (wr && waddr == 5'd14) ? wdata : m_epc;
    n_cause  = m_cause;
    if (wr && waddr == 5'd13) n_cause[9:8] = wdata[9:8];
    n_cause[15:10] = {intr[5] | m_timer, intr[4:0]};
    if (is_exc) begin
      if (!m_status[1]) begin
        n_epc = ds ? pc - 32'd4 : pc;
        n_cause[31] = ds;
      end
      n_status[1] = 1'b1;
      n_cause[6:2] = ref_exccode(exc);
    end else if (is_eret) begin
      n_status[1] = 1'b0;
    end
    #2;
    drain();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    m_status = n_status; m_cause = n_cause; m_epc = n_epc;
    m_count = n_count; m_compare = n_compare; m_timer = n_timer;
    push("status", S_STATUS, m_status);
    push("cause", S_CAUSE, m_cause);
    push("epc", S_EPC, m_epc);
    push("count", S_COUNT, m_count);
    push("compare", S_COMPARE, m_compare);
    push("timer_int", S_TIMER, {31'd0, m_timer});
    drain();
  endtask

  task automatic cyc(input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                     input logic [4:0] raddr, input logic [5:0] intr, input logic [31:0] exc,
                     input logic [31:0] pc, input logic ds);
    drive(we, waddr, wdata, raddr, intr, exc, pc, ds);
    tick();
  endtask

  task automatic idle();
    cyc(1'b0, 5'd0, 32'd0, 5'd12, 6'd0, 32'd0, 32'd0, 1'b0);
  endtask

  initial begin
    bus.we_i = 1'b0; bus.waddr_i = '0; bus.wdata_i = '0; bus.raddr_i = '0;
    bus.int_i = '0; bus.excepttype_i = '0; bus.pc_i = '0; bus.in_delayslot_i = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    want("rst_status", S_STATUS, SRST);
    want("rst_cause", S_CAUSE, 32'd0);
    want("rst_epc", S_EPC, 32'd0);
    want("rst_count", S_COUNT, 32'd0);
    want("rst_timer", S_TIMER, 32'd0);
    want("rst_flush", S_FLUSH, 32'd0);
    #7 rst = 1'b0;
    model_reset();

    repeat (5) idle();
    want("idle_count", S_COUNT, 32'd5);
    want("idle_status", S_STATUS, 32'h1000_0000);
    want("idle_cause", S_CAUSE, 32'd0);

    // Timer: Compare=10, then Count=0, match fires on the edge leaving Count==10.
    cyc(1'b1, 5'd11, 32'd10, 5'd11, 6'd0, 32'd0, 32'd0, 1'b0);
    cyc(1'b1, 5'd9, 32'd0, 5'd9, 6'd0, 32'd0, 32'd0, 1'b0);
    want("count_loaded", S_COUNT, 32'd0);
    repeat (10) idle();
    want("timer_before", S_TIMER, 32'd0);
    idle();
    want("timer_set", S_TIMER, 32'd1);
    check("ip7_lag", {31'd0, bus.cause_o[15]}, 32'd0);
    idle();
    check("ip7_set", {31'd0, bus.cause_o[15]}, 32'd1);
    cyc(1'b1, 5'd11, 32'd0, 5'd11, 6'd0, 32'd0, 32'd0, 1'b0);
    want("timer_clr", S_TIMER, 32'd0);
    cyc(1'b0, 5'd0, 32'd0, 5'd13, 6'b100101, 32'd0, 32'd0, 1'b0);
    check("hw_ip", {26'd0, bus.cause_o[15:10]}, 32'h25);

    // Syscall outside a delay slot.
    drive(1'b0, 5'd0, 32'd0, 5'd14, 6'd0, 32'd9, 32'h8000_0100, 1'b0);
    want("sys_flush", S_FLUSH, 32'd1);
    want("sys_newpc", S_NEWPC, 32'hBFC0_0380);
    tick();
    want("sys_epc", S_EPC, 32'h8000_0100);
    check("sys_exl", {31'd0, bus.status_o[1]}, 32'd1);
    check("sys_code", {27'd0, bus.cause_o[6:2]}, 32'd8);
    check("sys_bd", {31'd0, bus.cause_o[31]}, 32'd0);
    cyc(1'b0, 5'd0, 32'd0, 5'd0, 6'd0, 32'd13, 32'd0, 1'b0);

    // Overflow in a delay slot, then a nested AdEL.
    cyc(1'b0, 5'd0, 32'd0, 5'd13, 6'd0, 32'd11, 32'h8000_0204, 1'b1);
    want("ov_epc", S_EPC, 32'h8000_0200);
    check("ov_bd", {31'd0, bus.cause_o[31]}, 32'd1);
    check("ov_code", {27'd0, bus.cause_o[6:2]}, 32'd12);
    cyc(1'b0, 5'd0, 32'd0, 5'd14, 6'd0, 32'd12, 32'h8000_0300, 1'b0);
    want("nest_epc", S_EPC, 32'h8000_0200);
    check("nest_bd", {31'd0, bus.cause_o[31]}, 32'd1);

    drive(1'b0, 5'd0, 32'd0, 5'd0, 6'd0, 32'd13, 32'd0, 1'b0);
    want("eret_newpc", S_NEWPC, 32'h8000_0200);
    want("eret_flush", S_FLUSH, 32'd1);
    tick();
    check("eret_exl", {31'd0, bus.status_o[1]}, 32'd0);

    // MTC0 Status alongside an exception is dropped; alone it bypasses to MFC0.
    cyc(1'b1, 5'd12, 32'h0000_FF01, 5'd12, 6'd0, 32'd10, 32'h8000_0500, 1'b0);
    want("supp_status", S_STATUS, 32'h1000_0002);
    cyc(1'b0, 5'd0, 32'd0, 5'd0, 6'd0, 32'd13, 32'd0, 1'b0);
    drive(1'b1, 5'd12, 32'h0000_FF01, 5'd12, 6'd0, 32'd0, 32'd0, 1'b0);
    want("byp_status", S_RDATA, 32'h0000_FF01);
    tick();
    want("wr_status", S_STATUS, 32'h0000_FF01);

    cyc(1'b1, 5'd13, 32'hFFFF_FFFF, 5'd13, 6'd0, 32'd0, 32'd0, 1'b0);
    check("cause_sw", {30'd0, bus.cause_o[9:8]}, 32'd3);
    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 6'd0, 32'd0, 32'd0, 1'b0);
    want("unimpl_rd", S_RDATA, 32'd0);
    tick();
    drive(1'b1, 5'd14, 32'h1234_5678, 5'd14, 6'd0, 32'd0, 32'd0, 1'b0);
    want("byp_epc", S_RDATA, 32'h1234_5678);
    tick();

    cyc(1'b1, 5'd9, 32'hFFFF_FFFF, 5'd9, 6'd0, 32'd0, 32'd0, 1'b0);
    idle();
    want("count_wrap", S_COUNT, 32'd0);

    drive(1'b1, 5'd11, 32'd5, 5'd11, 6'd0, 32'd14, 32'h8000_0600, 1'b0);
    want("c14_flush", S_FLUSH, 32'd0);
    want("c14_newpc", S_NEWPC, 32'd0);
    tick();
    want("c14_wr", S_COMPARE, 32'd5);
    cyc(1'b0, 5'd0, 32'd0, 5'd9, 6'd0, 32'h8000_0009, 32'd0, 1'b0);
    repeat (6) idle();

    // Interrupt code in a delay slot.
    drive(1'b0, 5'd0, 32'd0, 5'd13, 6'd0, 32'd1, 32'h8000_0404, 1'b1);
    want("int_newpc", S_NEWPC, VEC);
    tick();
    want("int_epc", S_EPC, 32'h8000_0400);
    check("int_code", {27'd0, bus.cause_o[6:2]}, 32'd0);

    // Reset asserted mid-cycle while an exception is presented.
    bus.excepttype_i = 32'd9;
    rst = 1'b1;
    #2;
    want("rstx_flush", S_FLUSH, 32'd1);
    want("rstx_newpc", S_NEWPC, VEC);
    want("rstx_status", S_STATUS, SRST);
    want("rstx_count", S_COUNT, 32'd0);
    want("rstx_epc", S_EPC, 32'd0);
    #10;
    want("rstx_hold", S_STATUS, SRST);
    bus.excepttype_i = 32'd0;
    rst = 1'b0;
    #10;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
